// File: rtl/maze_controller.sv
// Control FSM for the rat-in-maze datapath: depth-first search with backtracking
// from (0,0) to GOAL, followed by stack-driven path playback.
module maze_controller #(
    parameter logic [7:0] GOAL = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cntReach,
    input  logic       empStck,
    input  logic [7:0] curLoc,
    input  logic [7:0] nxtLoc,
    input  logic       wall,
    output logic       rgLd,
    output logic [1:0] dir,
    output logic       push,
    output logic       pop,
    output logic       adderEn,
    output logic       done,
    output logic       run,
    output logic       busy,
    output logic       found,
    output logic       fail
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StCheck,
        StBack,
        StDone,
        StRun,
        StFin,
        StFail
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   dir_cnt_q, dir_cnt_d;
    logic [255:0] visited_q, visited_d;
    logic         busy_q, busy_d;
    logic         found_q, found_d;
    logic         fail_q, fail_d;
    logic         blocked;

    assign blocked = cntReach | wall | visited_q[nxtLoc];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            dir_cnt_q <= 2'd0;
            visited_q <= '0;
            busy_q    <= 1'b0;
            found_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_cnt_q <= dir_cnt_d;
            visited_q <= visited_d;
            busy_q    <= busy_d;
            found_q   <= found_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_cnt_d = dir_cnt_q;
        visited_d = visited_q;
        busy_d    = busy_q;
        found_d   = found_q;
        fail_d    = fail_q;
        rgLd      = 1'b0;
        dir       = 2'b00;
        push      = 1'b0;
        pop       = 1'b0;
        adderEn   = 1'b0;
        done      = 1'b0;
        run       = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) state_d = StInit;
            end
            StInit: begin
                visited_d[curLoc] = 1'b1;
                dir_cnt_d         = 2'd0;
                busy_d            = 1'b1;
                state_d           = StCheck;
            end
            StCheck: begin
                if (curLoc == GOAL) begin
                    state_d = StDone;
                end else begin
                    dir     = dir_cnt_q;
                    adderEn = 1'b1;
                    if (blocked) begin
                        if (dir_cnt_q == 2'd3) state_d = StBack;
                        else dir_cnt_d = dir_cnt_q + 2'd1;
                    end else begin
                        // Stack captures the old curLoc while the registers load nxtLoc.
                        push              = 1'b1;
                        rgLd              = 1'b1;
                        visited_d[nxtLoc] = 1'b1;
                        dir_cnt_d         = 2'd0;
                    end
                end
            end
            StBack: begin
                if (empStck) begin
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StFail;
                end else begin
                    pop       = 1'b1;
                    rgLd      = 1'b1;
                    dir_cnt_d = 2'd0;
                    state_d   = StCheck;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                if (empStck) begin
                    found_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StFin;
                end else begin
                    run = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy  = busy_q;
    assign found = found_q;
    assign fail  = fail_q;

endmodule
